obstacle_scroller: RTL and testbench

Consumer end of the obstacle-selection interface. It latches the selected obstacle type and width, scrolls the obstacle leftward one speed step per frame and reports its geometry to the renderer and collision logic. When the obstacle leaves the screen it pulses ObstacleRunning, which tells the obstacle selector to advance to the next type. It then waits an inter-obstacle gap and spawns the next obstacle.

---
 rtl/obstacle_pkg.sv | 47 ++++
 rtl/obstacle_geom_lut.sv | 38 +++
 rtl/obstacle_scroller.sv | 189 ++++++++++++++++++
 tb/tb_obstacle_scroller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// obstacle_pkg
// Shared definitions for the obstacle path: game-state codes, obstacle
// type codes, obstacle heights, default ground/bird lines, the scroller
// FSM state type and the packed {h, y} geometry record produced by the
// geometry lookup.
package obstacle_pkg;

    // gamestate codes; 2'b10 behaves like UnBegin (only bit 0 matters
    // for deciding "not started")
    localparam logic [1:0] GS_UNBEGIN = 2'b00;
    localparam logic [1:0] GS_RUNNING = 2'b01;
    localparam logic [1:0] GS_DEAD    = 2'b11;

    // obstacle type codes as driven by the selector
    localparam logic [3:0] SEL_BIRD  = 4'b1000;
    localparam logic [3:0] SEL_CAC1S = 4'b0100;
    localparam logic [3:0] SEL_CAC1B = 4'b0101;
    localparam logic [3:0] SEL_CAC2S = 4'b0110;
    localparam logic [3:0] SEL_CAC2B = 4'b0111;

    // obstacle heights in pixels
    localparam logic [9:0] H_SMALL = 10'd70;
    localparam logic [9:0] H_BIRD  = 10'd80;
    localparam logic [9:0] H_BIG   = 10'd100;

    localparam int GROUND_Y_DEF = 400;
    localparam int BIRD_Y_DEF   = 330;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCROLL,
        ST_EXIT,
        ST_GAP
    } obs_state_t;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] y;
    } obs_geom_t;

    // UnBegin is any code with bit 0 clear (00 and 10)
    function automatic logic is_unbegin(input logic [1:0] gs);
        return ~gs[0];
    endfunction

endpackage

// File: rtl/obstacle_geom_lut.sv
// obstacle_geom_lut
// Combinational map from obstacle type code to {height, top y}.
// Birds fly at BIRD_Y; cacti stand on GROUND_Y. Unknown codes fall
// back to the big cactus so a bad selector code still yields a sane,
// collidable shape.
// Ports:
//   sel   in  4          obstacle type code
//   geom  out obs_geom_t {h, y} of that type
module obstacle_geom_lut
    import obstacle_pkg::*;
#(
    parameter int GROUND_Y = GROUND_Y_DEF,
    parameter int BIRD_Y   = BIRD_Y_DEF
) (
    input  logic [3:0] sel,
    output obs_geom_t  geom
);

    localparam logic [9:0] GROUND = 10'(GROUND_Y);
    localparam logic [9:0] BIRD   = 10'(BIRD_Y);

    always_comb begin
        geom.h = H_BIG;
        geom.y = GROUND - H_BIG;
        case (sel)
            SEL_BIRD: begin
                geom.h = H_BIRD;
                geom.y = BIRD;
            end
            SEL_CAC1S, SEL_CAC2S: begin
                geom.h = H_SMALL;
                geom.y = GROUND - H_SMALL;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller
// Latches the selected obstacle, scrolls it left by `speed` pixels per
// frame, pulses ObstacleRunning/obstacle_passed for one cycle when it
// has fully left the screen, waits GAP_FRAMES frames and spawns the
// next one. Speed rises by one every STEP_EVERY cleared obstacles up to
// MAX_SPEED. Dead freezes everything; UnBegin restarts from reset values.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        one-cycle strobe per video frame
//   gamestate         00 UnBegin, 01 Running, 11 Dead, 10 as UnBegin
//   ObstacleSEL       type from selector (sampled only in LOAD)
//   FinalWidth        width from selector (sampled only in LOAD)
//   ObstacleRunning   one-cycle request for the next obstacle
//   obstacle_passed   one-cycle score pulse
//   obstacle_x        signed left edge
//   obstacle_y/w/h    latched geometry
//   obstacle_sel_o    latched type for the renderer
//   obstacle_visible  obstacle drawn / collidable
//   speed             current pixels per frame
module obstacle_scroller
    import obstacle_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int GROUND_Y    = GROUND_Y_DEF,
    parameter int BIRD_Y      = BIRD_Y_DEF,
    parameter int START_SPEED = 4,
    parameter int MAX_SPEED   = 12,
    parameter int STEP_EVERY  = 5,
    parameter int GAP_FRAMES  = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [1:0]         gamestate,
    input  logic [3:0]         ObstacleSEL,
    input  logic [9:0]         FinalWidth,
    output logic               ObstacleRunning,
    output logic               obstacle_passed,
    output logic signed [11:0] obstacle_x,
    output logic [9:0]         obstacle_y,
    output logic [9:0]         obstacle_w,
    output logic [9:0]         obstacle_h,
    output logic [3:0]         obstacle_sel_o,
    output logic               obstacle_visible,
    output logic [4:0]         speed
);

    localparam int PW = $clog2(STEP_EVERY + 1);
    localparam int GW = $clog2(GAP_FRAMES + 1);

    localparam logic signed [11:0] X_SPAWN   = 12'(SCREEN_W);
    localparam logic [4:0]         SPD_START = 5'(START_SPEED);
    localparam logic [4:0]         SPD_MAX   = 5'(MAX_SPEED);
    localparam logic [PW-1:0]      STEP_LAST = PW'(STEP_EVERY - 1);
    localparam logic [GW-1:0]      GAP_LOAD  = GW'(GAP_FRAMES);
    localparam logic [GW-1:0]      GAP_LAST  = GW'(1);

    obs_state_t         state_q, state_n;
    logic signed [11:0] x_q, x_n;
    logic [9:0]         y_q, y_n, w_q, w_n, h_q, h_n;
    logic [3:0]         sel_q, sel_n;
    logic [4:0]         speed_q, speed_n;
    logic [PW-1:0]      pass_q, pass_n;
    logic [GW-1:0]      gap_q, gap_n;

    obs_geom_t          geom;
    logic signed [12:0] rem;
    logic               gone;
    logic               frozen;

    obstacle_geom_lut #(
        .GROUND_Y (GROUND_Y),
        .BIRD_Y   (BIRD_Y)
    ) u_lut (
        .sel  (ObstacleSEL),
        .geom (geom)
    );

    // right edge after this frame's step; <= 0 means fully off screen.
    // One extra bit keeps the sum clear of overflow for any width.
    assign rem  = 13'(x_q) - $signed({8'b0, speed_q}) + $signed({3'b0, w_q});
    assign gone = rem[12] || (rem == 13'sd0);

    // Dead holds everything except an EXIT already in flight, so the
    // pulse it has started still ends after one cycle.
    assign frozen = (gamestate == GS_DEAD) && (state_q != ST_EXIT);

    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        w_n     = w_q;
        h_n     = h_q;
        sel_n   = sel_q;
        speed_n = speed_q;
        pass_n  = pass_q;
        gap_n   = gap_q;

        if (is_unbegin(gamestate)) begin
            state_n = ST_IDLE;
            x_n     = X_SPAWN;
            y_n     = '0;
            w_n     = '0;
            h_n     = '0;
            sel_n   = SEL_CAC2B;
            speed_n = SPD_START;
            pass_n  = '0;
            gap_n   = '0;
        end else if (!frozen) begin
            case (state_q)
                ST_IDLE: begin
                    if (gamestate == GS_RUNNING) state_n = ST_LOAD;
                end
                ST_LOAD: begin
                    sel_n   = ObstacleSEL;
                    w_n     = (FinalWidth == '0) ? 10'd1 : FinalWidth;
                    h_n     = geom.h;
                    y_n     = geom.y;
                    x_n     = X_SPAWN;
                    state_n = ST_SCROLL;
                end
                ST_SCROLL: begin
                    if (frame_tick) begin
                        if (gone) begin
                            x_n     = -$signed({2'b0, w_q});
                            state_n = ST_EXIT;
                        end else begin
                            x_n = x_q - $signed({7'b0, speed_q});
                        end
                    end
                end
                ST_EXIT: begin
                    if (pass_q == STEP_LAST) begin
                        pass_n = '0;
                        if (speed_q < SPD_MAX) speed_n = speed_q + 5'd1;
                    end else begin
                        pass_n = pass_q + PW'(1);
                    end
                    gap_n   = GAP_LOAD;
                    state_n = ST_GAP;
                end
                ST_GAP: begin
                    if (frame_tick) begin
                        gap_n = gap_q - GW'(1);
                        if (gap_q == GAP_LAST) state_n = ST_LOAD;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= X_SPAWN;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            sel_q   <= SEL_CAC2B;
            speed_q <= SPD_START;
            pass_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            w_q     <= w_n;
            h_q     <= h_n;
            sel_q   <= sel_n;
            speed_q <= speed_n;
            pass_q  <= pass_n;
            gap_q   <= gap_n;
        end
    end

    // Pulses follow the one-cycle EXIT state, so a reset or restart on
    // that edge drops them immediately.
    assign ObstacleRunning  = (state_q == ST_EXIT);
    assign obstacle_passed  = (state_q == ST_EXIT);
    assign obstacle_visible = (state_q == ST_SCROLL);
    assign obstacle_x       = x_q;
    assign obstacle_y       = y_q;
    assign obstacle_w       = w_q;
    assign obstacle_h       = h_q;
    assign obstacle_sel_o   = sel_q;
    assign speed            = speed_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Randomized bench for obstacle_scroller against a behavioural model of
// the obstacle's life: waiting -> loading -> on screen -> leaving ->
// gap -> loading ...
module tb_obstacle_scroller;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_tick;
    logic [1:0]         gamestate;
    logic [3:0]         ObstacleSEL;
    logic [9:0]         FinalWidth;
    logic               ObstacleRunning;
    logic               obstacle_passed;
    logic signed [11:0] obstacle_x;
    logic [9:0]         obstacle_y;
    logic [9:0]         obstacle_w;
    logic [9:0]         obstacle_h;
    logic [3:0]         obstacle_sel_o;
    logic               obstacle_visible;
    logic [4:0]         speed;

    obstacle_scroller dut (
        .clk              (clk),
        .rst              (rst),
        .frame_tick       (frame_tick),
        .gamestate        (gamestate),
        .ObstacleSEL      (ObstacleSEL),
        .FinalWidth       (FinalWidth),
        .ObstacleRunning  (ObstacleRunning),
        .obstacle_passed  (obstacle_passed),
        .obstacle_x       (obstacle_x),
        .obstacle_y       (obstacle_y),
        .obstacle_w       (obstacle_w),
        .obstacle_h       (obstacle_h),
        .obstacle_sel_o   (obstacle_sel_o),
        .obstacle_visible (obstacle_visible),
        .speed            (speed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_waiting, m_loading, m_onscreen, m_leaving, m_gapping;
    int m_x, m_y, m_w, m_h, m_sel, m_speed, m_passes, m_gap;
    int m_total;

    function automatic void model_reset();
        m_waiting = 1; m_loading = 0; m_onscreen = 0; m_leaving = 0; m_gapping = 0;
        m_x = 640; m_y = 0; m_w = 0; m_h = 0; m_sel = 7;
        m_speed = 4; m_passes = 0; m_gap = 0;
    endfunction

    function automatic void model_step(input bit r, input bit [1:0] g, input bit t,
                                       input int s, input int f);
        if (r || g == 2'b00 || g == 2'b10) begin
            model_reset();
        end else if (g == 2'b11 && !m_leaving) begin
            // frozen
        end else if (m_waiting) begin
            m_waiting = 0; m_loading = 1;
        end else if (m_loading) begin
            m_sel = s;
            m_w = (f == 0) ? 1 : f;
            if (s == 8) begin m_h = 80; m_y = 330; end
            else if (s == 4 || s == 6) begin m_h = 70; m_y = 400 - 70; end
            else begin m_h = 100; m_y = 400 - 100; end
            m_x = 640;
            m_loading = 0; m_onscreen = 1;
        end else if (m_onscreen) begin
            if (t) begin
                if (m_x - m_speed + m_w <= 0) begin
                    m_x = -m_w; m_onscreen = 0; m_leaving = 1;
                end else begin
                    m_x = m_x - m_speed;
                end
            end
        end else if (m_leaving) begin
            m_leaving = 0;
            m_total++;
            m_passes++;
            if (m_passes == 5) begin
                m_passes = 0;
                if (m_speed < 12) m_speed++;
            end
            m_gap = 30; m_gapping = 1;
        end else if (m_gapping) begin
            if (t) begin
                m_gap--;
                if (m_gap == 0) begin m_gapping = 0; m_loading = 1; end
            end
        end
    endfunction

    // ---------------- per-cycle checking ----------------
    bit prev_run = 0;
    int dut_pulses = 0;
    int max_speed_seen = 0;

    task automatic compare_all();
        chk("x",       $signed(obstacle_x), m_x);
        chk("y",       obstacle_y, m_y);
        chk("w",       obstacle_w, m_w);
        chk("h",       obstacle_h, m_h);
        chk("sel",     obstacle_sel_o, m_sel);
        chk("visible", obstacle_visible, m_onscreen);
        chk("running", ObstacleRunning, m_leaving);
        chk("passed",  obstacle_passed, m_leaving);
        chk("speed",   speed, m_speed);
        chk("pulse_b2b", int'(prev_run & ObstacleRunning), 0);
        prev_run = ObstacleRunning;
        if (obstacle_passed) dut_pulses++;
        if (int'(speed) > max_speed_seen) max_speed_seen = speed;
    endtask

    int dead_left = 0;
    int unb_left  = 0;
    int unb_code  = 0;

    // mode 0: running with Dead bursts; mode 1: adds restarts and resets
    task automatic step(input int mode);
        bit [3:0] sel_tab [8] = '{4'b1000, 4'b0100, 4'b0101, 4'b0110,
                                  4'b0111, 4'b0011, 4'b0000, 4'b1111};
        compare_all();
        rst = 1'b0;
        frame_tick = ($urandom_range(0, 3) != 0);
        ObstacleSEL = sel_tab[$urandom_range(0, 7)];
        case ($urandom_range(0, 9))
            0:       FinalWidth = 10'd0;
            1:       FinalWidth = 10'(1023 - $urandom_range(0, 3));
            default: FinalWidth = 10'($urandom_range(1, 200));
        endcase
        if (dead_left == 0 && unb_left == 0) begin
            if ($urandom_range(0, 299) == 0) dead_left = $urandom_range(1, 60);
            else if (mode == 1 && $urandom_range(0, 199) == 0) begin
                unb_left = $urandom_range(1, 5);
                unb_code = $urandom_range(0, 1) ? 2 : 0;
            end
        end
        if (dead_left > 0) begin gamestate = 2'b11; dead_left--; end
        else if (unb_left > 0) begin gamestate = 2'(unb_code); unb_left--; end
        else gamestate = 2'b01;
        if (mode == 1 && ((m_leaving && $urandom_range(0, 2) == 0) ||
                          $urandom_range(0, 499) == 0))
            rst = 1'b1;
        model_step(rst, gamestate, frame_tick, ObstacleSEL, FinalWidth);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; gamestate = 2'b00; frame_tick = 1'b0;
        ObstacleSEL = 4'b0000; FinalWidth = 10'd0;
        model_reset();
        m_total = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("rst_x",       $signed(obstacle_x), 640);
        chk("rst_y",       obstacle_y, 0);
        chk("rst_w",       obstacle_w, 0);
        chk("rst_h",       obstacle_h, 0);
        chk("rst_sel",     obstacle_sel_o, 7);
        chk("rst_visible", obstacle_visible, 0);
        chk("rst_running", ObstacleRunning, 0);
        chk("rst_passed",  obstacle_passed, 0);
        chk("rst_speed",   speed, 4);

        // long run: enough clears to reach speed saturation
        cyc = 0;
        while (m_total < 47 && cyc < 60000 && errors < 30) begin
            step(0);
            cyc++;
        end
        chk("pass_budget", int'(dut_pulses >= 45), 1);
        chk("speed_max", max_speed_seen, 12);

        // restarts, Dead and resets mixed in
        cyc = 0;
        while (cyc < 15000 && errors < 30) begin
            step(1);
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
